bram_share_arbiter: RTL

- Shares the single-port user BRAM (32-bit words, 1-cycle read latency) between two requesters.
  - The Wishbone slave path used by firmware.
  - A streaming engine port used by the FIR datapath for tap/data fetch and writeback.
- Sequences the Wishbone access with a programmable wait-state delay.
- Arbitrates each BRAM cycle between the two requesters and returns read data to the owner.

---
 rtl/bram_share_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bram_share_arbiter.sv
// Shares one single-port BRAM between the Wishbone slave path and the FIR engine port.
// Define ARB_ENG_PRIORITY_EN to let the engine win every contested cycle.
module bram_share_arbiter #(
   parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
   parameter int unsigned WB_DELAY  = 10,
   parameter int unsigned ADDR_W    = 12
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic              eng_req,
   input  logic              eng_we,
   input  logic [3:0]        eng_sel,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic [31:0]       eng_wdata,
   output logic              eng_gnt,
   output logic              eng_rvalid,
   output logic [31:0]       eng_rdata,
   output logic              bram_en,
   output logic [3:0]        bram_we,
   output logic [31:0]       bram_a,
   output logic [31:0]       bram_di,
   input  logic [31:0]       bram_do
);

   typedef enum logic [2:0] {
      W_IDLE,
      W_DELAY,
      W_PEND,
      W_RCAP,
      W_ACK
   } wb_state_t;

   localparam logic [3:0] CNT_LAST = 4'(WB_DELAY - 1);

   wb_state_t   state;
   wb_state_t   state_nxt;
   logic [3:0]  cnt;
   logic        wb_pend;
   logic        eng_elig;
   logic        wb_gnt;
   logic        eng_wins_tie;
   logic [31:0] wb_word;

   assign wb_pend  = (state == W_PEND) && wbs_cyc_i;
   // Engine eligibility is gated so outputs drop the moment reset asserts.
   assign eng_elig = eng_req && !wb_rst_i;
   assign wb_word  = (wbs_adr_i - BASE_ADDR) >> 2;

`ifdef ARB_ENG_PRIORITY_EN
   assign eng_wins_tie = 1'b1;
`else
   logic last_eng;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         last_eng <= 1'b0;
      end else if (wb_pend && eng_elig) begin
         last_eng <= eng_gnt;
      end
   end

   assign eng_wins_tie = !last_eng;
`endif

   always_comb begin
      wb_gnt  = 1'b0;
      eng_gnt = 1'b0;
      if (wb_pend && eng_elig) begin
         eng_gnt = eng_wins_tie;
         wb_gnt  = !eng_wins_tie;
      end else begin
         wb_gnt  = wb_pend;
         eng_gnt = eng_elig;
      end
   end

   always_comb begin
      bram_en = 1'b0;
      bram_we = 4'h0;
      bram_a  = 32'h0;
      bram_di = 32'h0;
      if (wb_gnt) begin
         bram_en = 1'b1;
         bram_we = wbs_we_i ? wbs_sel_i : 4'h0;
         bram_a  = wb_word;
         bram_di = wbs_dat_i;
      end else if (eng_gnt) begin
         bram_en = 1'b1;
         bram_we = eng_we ? eng_sel : 4'h0;
         bram_a  = 32'(eng_addr);
         bram_di = eng_wdata;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= W_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         W_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) state_nxt = W_DELAY;
         end
         W_DELAY: begin
            if (!wbs_cyc_i) state_nxt = W_IDLE;
            else if (cnt == CNT_LAST) state_nxt = W_PEND;
         end
         W_PEND: begin
            if (!wbs_cyc_i) state_nxt = W_IDLE;
            else if (wb_gnt) state_nxt = wbs_we_i ? W_ACK : W_RCAP;
         end
         W_RCAP:  state_nxt = W_ACK;
         W_ACK:   state_nxt = W_IDLE;
         default: state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt <= 4'h0;
      end else if (state == W_DELAY) begin
         cnt <= cnt + 4'h1;
      end else begin
         cnt <= 4'h0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wbs_dat_o <= 32'h0;
      end else if (state == W_RCAP) begin
         wbs_dat_o <= bram_do;
      end
   end

   assign wbs_ack_o = (state == W_ACK);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         eng_rvalid <= 1'b0;
      end else begin
         eng_rvalid <= eng_gnt && !eng_we;
      end
   end

   // BRAM output is already a register stage, so read data passes straight through.
   assign eng_rdata = eng_rvalid ? bram_do : 32'h0;

endmodule
